// File: rtl/vscale_wb_arbiter_if.sv
// rtl/vscale_wb_arbiter_if.sv - writeback arbiter bus bundle (pipeline, md unit, issue stage, register file)
interface vscale_wb_arbiter_if #(
    parameter int XPR_LEN        = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      ex_wen;
    logic [REG_ADDR_WIDTH-1:0] ex_wa;
    logic [XPR_LEN-1:0]        ex_wd;
    logic                      md_req_valid;
    logic [REG_ADDR_WIDTH-1:0] md_req_wa;
    logic                      md_busy;
    logic                      md_resp_valid;
    logic [XPR_LEN-1:0]        md_resp_data;
    logic                      md_resp_ready;
    logic [REG_ADDR_WIDTH-1:0] id_ra1;
    logic [REG_ADDR_WIDTH-1:0] id_ra2;
    logic [REG_ADDR_WIDTH-1:0] id_wa;
    logic                      hazard;
    logic [XPR_LEN-1:0]        rf_rd1;
    logic [XPR_LEN-1:0]        rf_rd2;
    logic [XPR_LEN-1:0]        rd1;
    logic [XPR_LEN-1:0]        rd2;
    logic                      rf_wen;
    logic [REG_ADDR_WIDTH-1:0] rf_wa;
    logic [XPR_LEN-1:0]        rf_wd;

    modport slave (
        input  ex_wen, ex_wa, ex_wd,
        input  md_req_valid, md_req_wa, md_resp_valid, md_resp_data,
        output md_busy, md_resp_ready,
        input  id_ra1, id_ra2, id_wa,
        output hazard,
        input  rf_rd1, rf_rd2,
        output rd1, rd2,
        output rf_wen, rf_wa, rf_wd
    );

    modport master (
        output ex_wen, ex_wa, ex_wd,
        output md_req_valid, md_req_wa, md_resp_valid, md_resp_data,
        input  md_busy, md_resp_ready,
        output id_ra1, id_ra2, id_wa,
        input  hazard,
        output rf_rd1, rf_rd2,
        input  rd1, rd2,
        input  rf_wen, rf_wa, rf_wd
    );
endinterface

// File: rtl/vscale_wb_arbiter.sv
// rtl/vscale_wb_arbiter.sv - register-file write-port arbiter with md scoreboard and read bypass
module vscale_wb_arbiter #(
    parameter int XPR_LEN        = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    vscale_wb_arbiter_if.slave  wb
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                    state, state_nxt;
    logic [REG_ADDR_WIDTH-1:0] tag, tag_nxt;
    logic [XPR_LEN-1:0]        hold_data, hold_data_nxt;

    logic                      ex_pend;
    logic                      resp_fire;
    logic                      md_write;
    logic [XPR_LEN-1:0]        md_data;
    logic                      wen_raw;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tag       <= '0;
            hold_data <= '0;
        end else begin
            state     <= state_nxt;
            tag       <= tag_nxt;
            hold_data <= hold_data_nxt;
        end
    end

    assign ex_pend   = wb.ex_wen && (wb.ex_wa != '0);
    assign resp_fire = (state == WAIT) && wb.md_resp_valid;

    // The md result only reaches the port when the pipeline leaves it free.
    always_comb begin
        md_write = 1'b0;
        md_data  = hold_data;
        if (resp_fire) begin
            md_write = !ex_pend;
            md_data  = wb.md_resp_data;
        end else if (state == HOLD) begin
            md_write = !ex_pend;
        end
    end

    always_comb begin
        state_nxt     = state;
        tag_nxt       = tag;
        hold_data_nxt = hold_data;
        case (state)
            IDLE: begin
                if (wb.md_req_valid) begin
                    tag_nxt   = wb.md_req_wa;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (resp_fire) begin
                    if (ex_pend) begin
                        hold_data_nxt = wb.md_resp_data;
                        state_nxt     = HOLD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            HOLD: begin
                if (!ex_pend)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wen_raw  = 1'b0;
        wb.rf_wa = wb.ex_wa;
        wb.rf_wd = wb.ex_wd;
        if (ex_pend) begin
            wen_raw = 1'b1;
        end else if (md_write) begin
            wen_raw  = (tag != '0);
            wb.rf_wa = tag;
            wb.rf_wd = md_data;
        end
    end

    assign wb.rf_wen        = reset_n && wen_raw;
    assign wb.md_busy       = (state != IDLE);
    assign wb.md_resp_ready = (state == WAIT);

    // Matching id_wa as well as the sources blocks WAW on the pending destination.
    assign wb.hazard = (state != IDLE) && (tag != '0) &&
                       ((wb.id_ra1 == tag) || (wb.id_ra2 == tag) || (wb.id_wa == tag));

    always_comb begin
        if (wb.id_ra1 == '0)
            wb.rd1 = '0;
        else if (wb.rf_wen && (wb.rf_wa == wb.id_ra1))
            wb.rd1 = wb.rf_wd;
        else
            wb.rd1 = wb.rf_rd1;
    end

    always_comb begin
        if (wb.id_ra2 == '0)
            wb.rd2 = '0;
        else if (wb.rf_wen && (wb.rf_wa == wb.id_ra2))
            wb.rd2 = wb.rf_wd;
        else
            wb.rd2 = wb.rf_rd2;
    end
endmodule

// File: tb/tb_vscale_wb_arbiter.sv
// tb/tb_vscale_wb_arbiter.sv - directed and random checks of vscale_wb_arbiter against a transaction-level model
module tb_vscale_wb_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    vscale_wb_arbiter_if #(.XPR_LEN(32), .REG_ADDR_WIDTH(5)) bus ();

    vscale_wb_arbiter #(.XPR_LEN(32), .REG_ADDR_WIDTH(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wb      (bus)
    );

    always #5 clk = ~clk;

    // Model: an outstanding md op, and at most one accepted result still waiting for the port.
    bit          m_out;
    bit          m_has;
    logic [4:0]  m_tag;
    logic [31:0] m_res;

    bit          e_accept;
    bit          e_mdw;
    bit          e_wen;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.ex_wen = 0; bus.ex_wa = 0; bus.ex_wd = 0;
        bus.md_req_valid = 0; bus.md_req_wa = 0;
        bus.md_resp_valid = 0; bus.md_resp_data = 0;
        bus.id_ra1 = 0; bus.id_ra2 = 0; bus.id_wa = 0;
        bus.rf_rd1 = 32'h1111_1111; bus.rf_rd2 = 32'h2222_2222;
    endtask

    function automatic logic [31:0] bypass(input logic [4:0] ra, input logic [31:0] raw);
        if (ra == 0) return 32'h0;
        if (e_wen && e_wa == ra) return e_wd;
        return raw;
    endfunction

    // Check all outputs at the falling edge against the model.
    task automatic settle();
        bit ex_pend;
        @(negedge clk);
        ex_pend  = bus.ex_wen && bus.ex_wa != 0;
        e_accept = m_out && !m_has && bus.md_resp_valid;
        e_mdw    = m_out && (m_has || e_accept) && !ex_pend;
        e_wen    = ex_pend || (e_mdw && m_tag != 0);
        e_wa     = ex_pend ? bus.ex_wa : m_tag;
        e_wd     = ex_pend ? bus.ex_wd : (m_has ? m_res : bus.md_resp_data);
        chk("md_busy", 32'(bus.md_busy), 32'(m_out));
        chk("md_resp_ready", 32'(bus.md_resp_ready), 32'(m_out && !m_has));
        chk("hazard", 32'(bus.hazard), 32'(m_out && m_tag != 0 &&
            (bus.id_ra1 == m_tag || bus.id_ra2 == m_tag || bus.id_wa == m_tag)));
        chk("rf_wen", 32'(bus.rf_wen), 32'(e_wen));
        if (e_wen) begin
            chk("rf_wa", 32'(bus.rf_wa), 32'(e_wa));
            chk("rf_wd", bus.rf_wd, e_wd);
        end
        chk("rd1", bus.rd1, bypass(bus.id_ra1, bus.rf_rd1));
        chk("rd2", bus.rd2, bypass(bus.id_ra2, bus.rf_rd2));
    endtask

    task automatic advance();
        bit was_out;
        @(posedge clk);
        was_out = m_out;
        if (e_mdw) begin
            m_out = 0;
            m_has = 0;
        end else if (e_accept) begin
            m_has = 1;
            m_res = bus.md_resp_data;
        end
        if (!was_out && bus.md_req_valid) begin
            m_out = 1;
            m_tag = bus.md_req_wa;
        end
        #1;
    endtask

    task automatic model_reset();
        m_out = 0; m_has = 0; m_tag = 0; m_res = 0;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        bus.ex_wen = 1; bus.ex_wa = 4;
        #2;
        chk("reset rf_wen", 32'(bus.rf_wen), 32'h0);
        chk("reset md_busy", 32'(bus.md_busy), 32'h0);
        chk("reset ready", 32'(bus.md_resp_ready), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        idle_inputs();
        settle(); advance();

        // Pipeline write and bypass
        bus.ex_wen = 1; bus.ex_wa = 3; bus.ex_wd = 32'h1234; bus.id_ra1 = 3; bus.rf_rd1 = 32'hDEAD;
        settle();
        chk("ex rf_wa", 32'(bus.rf_wa), 32'h3);
        chk("ex rd1 bypass", bus.rd1, 32'h1234);
        advance();
        bus.ex_wa = 0;
        settle();
        chk("ex x0 rf_wen", 32'(bus.rf_wen), 32'h0);
        advance();
        bus.ex_wa = 3; bus.id_ra1 = 0;
        settle();
        chk("rd1 x0", bus.rd1, 32'h0);
        advance();

        // md op to x7, response three cycles later, no ex write
        idle_inputs();
        bus.md_req_valid = 1; bus.md_req_wa = 7;
        settle(); advance();
        bus.md_req_valid = 0; bus.id_ra2 = 7;
        repeat (2) begin
            settle();
            chk("wait hazard x7", 32'(bus.hazard), 32'h1);
            advance();
        end
        bus.md_resp_valid = 1; bus.md_resp_data = 32'hCAFE;
        settle();
        chk("md rf_wa", 32'(bus.rf_wa), 32'h7);
        chk("md rf_wd", bus.rf_wd, 32'hCAFE);
        chk("md rd2 bypass", bus.rd2, 32'hCAFE);
        advance();
        bus.md_resp_valid = 0;
        settle();
        chk("post-write hazard", 32'(bus.hazard), 32'h0);
        advance();

        // Response collides with two cycles of ex writes
        bus.md_req_valid = 1; bus.md_req_wa = 7;
        settle(); advance();
        bus.md_req_valid = 0;
        settle(); advance();
        bus.md_resp_valid = 1; bus.md_resp_data = 32'hBEEF;
        bus.ex_wen = 1; bus.ex_wa = 2; bus.ex_wd = 32'h22;
        settle(); chk("collide ex wins", 32'(bus.rf_wa), 32'h2); advance();
        bus.md_resp_valid = 0; bus.md_resp_data = 0;
        settle(); chk("hold busy", 32'(bus.md_busy), 32'h1); advance();
        bus.ex_wen = 0;
        settle();
        chk("hold write wa", 32'(bus.rf_wa), 32'h7);
        chk("hold write wd", bus.rf_wd, 32'hBEEF);
        advance();
        settle(); chk("hold done busy", 32'(bus.md_busy), 32'h0); advance();

        // md op to x0
        idle_inputs();
        bus.md_req_valid = 1; bus.md_req_wa = 0;
        settle(); advance();
        bus.md_req_valid = 0;
        settle(); chk("x0 hazard", 32'(bus.hazard), 32'h0); advance();
        bus.md_resp_valid = 1; bus.md_resp_data = 32'h55;
        settle(); chk("x0 rf_wen", 32'(bus.rf_wen), 32'h0); advance();
        bus.md_resp_valid = 0;
        settle(); advance();

        // Second request during WAIT is ignored
        bus.md_req_valid = 1; bus.md_req_wa = 7;
        settle(); advance();
        bus.md_req_wa = 9; bus.id_ra1 = 9;
        settle(); chk("ignored req x9", 32'(bus.hazard), 32'h0); advance();
        bus.md_req_valid = 0; bus.id_ra1 = 7;
        settle(); chk("tag stays x7", 32'(bus.hazard), 32'h1); advance();
        bus.md_resp_valid = 1; bus.md_resp_data = 32'h77;
        settle(); advance();
        idle_inputs();
        settle(); advance();

        // Reset in the middle of WAIT with tag 5
        bus.md_req_valid = 1; bus.md_req_wa = 5;
        settle(); advance();
        bus.md_req_valid = 0; bus.id_ra1 = 5; bus.ex_wen = 1; bus.ex_wa = 6;
        #1 reset_n = 0;
        #1;
        chk("async reset busy", 32'(bus.md_busy), 32'h0);
        chk("async reset hazard", 32'(bus.hazard), 32'h0);
        chk("async reset rf_wen", 32'(bus.rf_wen), 32'h0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1;
        idle_inputs();
        bus.id_ra1 = 5; bus.md_resp_valid = 1; bus.md_resp_data = 32'h99;
        settle();
        chk("post-reset ready", 32'(bus.md_resp_ready), 32'h0);
        advance();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus.ex_wen        = ($urandom_range(0, 2) == 0);
            bus.ex_wa         = 5'($urandom_range(0, 7));
            bus.ex_wd         = $urandom;
            bus.md_req_valid  = ($urandom_range(0, 3) == 0);
            bus.md_req_wa     = 5'($urandom_range(0, 7));
            bus.md_resp_valid = ($urandom_range(0, 2) == 0);
            bus.md_resp_data  = $urandom;
            bus.id_ra1        = 5'($urandom_range(0, 7));
            bus.id_ra2        = 5'($urandom_range(0, 7));
            bus.id_wa         = 5'($urandom_range(0, 7));
            bus.rf_rd1        = $urandom;
            bus.rf_rd2        = $urandom;
            settle();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
